// File: rtl/sat_mac_pipe.sv
// sat_mac_pipe: pipelined saturating fixed-point multiply-accumulate.
// Stage S1 registers operands, S2 holds the full-precision product, S3 holds
// the running sum. A final output register holds the scaled and clipped result.
// Every stage advances together on adv = ~out_valid | out_ready.
// Optional build macro SAT_MAC_ROUND_EN: round half up before clipping
// instead of truncating toward -inf.
module sat_mac_pipe #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 10,
    parameter int GUARD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat
);
    localparam int PROD_W = 2 * WIDTH;
    localparam int ACC_W  = PROD_W + GUARD;

    // Clip limits and rounding constant, one bit wider than the accumulator.
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - WIDTH){1'b1}}, {(WIDTH - 1){1'b0}}};
`ifdef SAT_MAC_ROUND_EN
    localparam logic signed [ACC_W:0] RND_C   = {{ACC_W{1'b0}}, 1'b1} << (FRAC - 1);
`endif

    logic                     adv;

    logic                     s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]         s1_a_q, s1_a_d;
    logic [WIDTH-1:0]         s1_b_q, s1_b_d;
    logic                     s1_first_q, s1_first_d;
    logic                     s1_last_q, s1_last_d;

    logic                     s2_valid_q, s2_valid_d;
    logic [PROD_W-1:0]        s2_prod_q, s2_prod_d;
    logic                     s2_first_q, s2_first_d;
    logic                     s2_last_q, s2_last_d;

    logic                     s3_valid_q, s3_valid_d;
    logic                     s3_last_q, s3_last_d;
    logic [ACC_W-1:0]         acc_q, acc_d;

    logic                     out_valid_q, out_valid_d;
    logic [WIDTH-1:0]         out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;

    logic [PROD_W-1:0]        a_ext, b_ext, prod;
    logic [ACC_W-1:0]         prod_acc;
    logic signed [ACC_W:0]    acc_x;
    logic signed [ACC_W:0]    scaled;
    logic [WIDTH-1:0]         res_data;
    logic                     res_sat;

    assign adv       = ~out_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // Full-precision signed product; sign-extending to 2*WIDTH keeps the low bits exact.
    always_comb begin
        a_ext    = {{WIDTH{s1_a_q[WIDTH-1]}}, s1_a_q};
        b_ext    = {{WIDTH{s1_b_q[WIDTH-1]}}, s1_b_q};
        prod     = a_ext * b_ext;
        prod_acc = {{GUARD{s2_prod_q[PROD_W-1]}}, s2_prod_q};
    end

    // Scale the completed sum back to the operand Q-format and clip to WIDTH bits.
    always_comb begin
`ifdef SAT_MAC_ROUND_EN
        // The extra top bit keeps the rounding add from wrapping.
        acc_x = $signed({acc_q[ACC_W-1], acc_q}) + RND_C;
`else
        acc_x = $signed({acc_q[ACC_W-1], acc_q});
`endif
        scaled = acc_x >>> FRAC;
        if (scaled > SAT_MAX) begin
            res_data = {1'b0, {(WIDTH - 1){1'b1}}};
            res_sat  = 1'b1;
        end else if (scaled < SAT_MIN) begin
            res_data = {1'b1, {(WIDTH - 1){1'b0}}};
            res_sat  = 1'b1;
        end else begin
            res_data = scaled[WIDTH-1:0];
            res_sat  = 1'b0;
        end
    end

    // Next-state for every stage: hold everything on stall, shift on adv.
    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        s2_valid_d  = s2_valid_q;
        s2_prod_d   = s2_prod_q;
        s2_first_d  = s2_first_q;
        s2_last_d   = s2_last_q;
        s3_valid_d  = s3_valid_q;
        s3_last_d   = s3_last_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (adv) begin
            s1_valid_d = in_valid;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_first_d = in_first;
            s1_last_d  = in_last;

            s2_valid_d = s1_valid_q;
            s2_prod_d  = prod;
            s2_first_d = s1_first_q;
            s2_last_d  = s1_last_q;

            s3_valid_d = s2_valid_q;
            s3_last_d  = s2_last_q;
            // Bubbles leave the sum untouched; first restarts it, otherwise wrap-add.
            if (s2_valid_q) begin
                acc_d = s2_first_q ? prod_acc : acc_q + prod_acc;
            end

            // A completing last loads a fresh result; otherwise adv means any
            // pending result was just taken (or there was none), so drop valid.
            out_valid_d = s3_valid_q & s3_last_q;
            if (s3_valid_q & s3_last_q) begin
                out_data_d = res_data;
                out_sat_d  = res_sat;
            end
        end
    end

    // Stage registers, accumulator and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset too; they are few and it makes the idle outputs defined.
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_prod_q   <= '0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so all stages sample the pre-edge values of their neighbours.
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_prod_q   <= s2_prod_d;
            s2_first_q  <= s2_first_d;
            s2_last_q   <= s2_last_d;
            s3_valid_q  <= s3_valid_d;
            s3_last_q   <= s3_last_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_sat_mac_pipe.sv
// Self-checking bench for sat_mac_pipe (WIDTH=16, FRAC=10, GUARD=4).
// Honours SAT_MAC_ROUND_EN for the expected values of the rounding vectors.
module tb_sat_mac_pipe;
    localparam int WIDTH = 16;
    localparam int FRAC  = 10;
    localparam int GUARD = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a = '0;
    logic [WIDTH-1:0]  in_b = '0;
    logic              in_first = 1'b0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  out_data;
    logic              out_sat;

    int checks = 0;
    int errors = 0;

    sat_mac_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .GUARD(GUARD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model: plain integer arithmetic ----------------
    longint         macc = 0;
    logic [16:0]    exp_q[$];   // {sat, data} in acceptance order
    logic [16:0]    got_q[$];   // {sat, data} as delivered by the DUT
    logic           hold_pend = 1'b0;
    logic [15:0]    hold_data;
    logic           hold_sat;

    function automatic logic [16:0] model_scale(input longint acc);
        longint s;
`ifdef SAT_MAC_ROUND_EN
        s = (acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
`else
        s = acc >>> FRAC;
`endif
        if (s > 32767)  return {1'b1, 16'h7FFF};
        if (s < -32768) return {1'b1, 16'h8000};
        return {1'b0, s[15:0]};
    endfunction

    task automatic model_accept(input logic [15:0] a, input logic [15:0] b,
                                input logic first, input logic last);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        macc = first ? p : macc + p;
        macc = (macc <<< (64 - (2 * WIDTH + GUARD))) >>> (64 - (2 * WIDTH + GUARD));
        if (last) exp_q.push_back(model_scale(macc));
    endtask

    // Monitor on the falling edge: handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            macc = 0;
            exp_q.delete();
            hold_pend = 1'b0;
        end else begin
            check("in_ready_vs_stall", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
            if (hold_pend) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_data", {16'b0, out_data}, {16'b0, hold_data});
                check("hold_sat", {31'b0, out_sat}, {31'b0, hold_sat});
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            hold_sat  = out_sat;
            if (in_valid && in_ready) model_accept(in_a, in_b, in_first, in_last);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output: got data 0x%0h, expected no result", out_data);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    check("model_data", {16'b0, out_data}, {16'b0, e[15:0]});
                    check("model_sat", {31'b0, out_sat}, {31'b0, e[16]});
                end
                got_q.push_back({out_sat, out_data});
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                             input logic first, input logic last);
        logic ok;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_first = first;
        in_last = last;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected acceptance");
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_results(input int n, input string name);
        int cyc = 0;
        while (got_q.size() < n && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (got_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d results, expected %0d", name, got_q.size(), n);
        end
    endtask

    task automatic expect_result(input string name, input logic [15:0] data, input logic sat);
        logic [16:0] r;
        r = (got_q.size() > 0) ? got_q.pop_front() : 17'h1_FFFF;
        check({name, "_data"}, {16'b0, r[15:0]}, {16'b0, data});
        check({name, "_sat"}, {31'b0, r[16]}, {31'b0, sat});
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        first;
        logic        last;
        logic        chk;
        logic [15:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{16'h0800, 16'h0C00, 1'b1, 1'b1, 1'b1, 16'h1800, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b1, 16'h7FFF, 1'b1};
        vecs[2]  = '{16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b1};
        vecs[3]  = '{16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1, 16'h7FFF, 1'b1};
`ifdef SAT_MAC_ROUND_EN
        vecs[4]  = '{16'h0001, 16'h0200, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0};
        vecs[5]  = '{16'hFFFF, 16'h0200, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0};
`else
        vecs[4]  = '{16'h0001, 16'h0200, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0};
        vecs[5]  = '{16'hFFFF, 16'h0200, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0};
`endif
        vecs[6]  = '{16'h0400, 16'h0200, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[7]  = '{16'h0400, 16'h0200, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[8]  = '{16'h0400, 16'h0200, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[9]  = '{16'h0400, 16'h0200, 1'b0, 1'b1, 1'b1, 16'h0800, 1'b0};
        vecs[10] = '{16'h0400, 16'h0400, 1'b1, 1'b1, 1'b1, 16'h0400, 1'b0};

        // Reset state.
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {16'b0, out_data}, 32'd0);
        check("rst_out_sat", {31'b0, out_sat}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single product with exact latency.
        send_beat(16'h0800, 16'h0C00, 1'b1, 1'b1);
        idle();
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("latency_edge_t+%0d", k), {31'b0, out_valid}, (k == 3) ? 32'd1 : 32'd0);
        end
        wait_results(1, "latency");
        expect_result("latency", 16'h1800, 1'b0);

        // Table-driven vectors, one beat at a time.
        for (int i = 0; i < 11; i++) begin
            send_beat(vecs[i].a, vecs[i].b, vecs[i].first, vecs[i].last);
            idle();
            if (vecs[i].chk) begin
                wait_results(1, $sformatf("vec%0d", i));
                expect_result($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_sat);
            end
        end

        // Back-to-back: 4-beat frame immediately followed by a single product.
        send_beat(16'h0400, 16'h0200, 1'b1, 1'b0);
        send_beat(16'h0400, 16'h0200, 1'b0, 1'b0);
        send_beat(16'h0400, 16'h0200, 1'b0, 1'b0);
        send_beat(16'h0400, 16'h0200, 1'b0, 1'b1);
        send_beat(16'h0400, 16'h0400, 1'b1, 1'b1);
        idle();
        wait_results(2, "b2b");
        expect_result("b2b_frame", 16'h0800, 1'b0);
        expect_result("b2b_single", 16'h0400, 1'b0);

        // Backpressure: 8 singles while out_ready follows 1,0,0,1,...
        begin
            logic       bp_done;
            logic [3:0] pat;
            bp_done = 1'b0;
            pat = 4'b1001;
            fork
                begin
                    for (int k = 1; k <= 8; k++)
                        send_beat(16'(k << 10), 16'h0400, 1'b1, 1'b1);
                    idle();
                    bp_done = 1'b1;
                end
                begin
                    for (int j = 0; j < 80 && !bp_done; j++) begin
                        out_ready = pat[j % 4];
                        @(posedge clk);
                        #1;
                    end
                end
            join
            out_ready = 1'b1;
        end
        wait_results(8, "bp");
        for (int k = 1; k <= 8; k++)
            expect_result($sformatf("bp%0d", k), 16'(k << 10), 1'b0);

        // Reset in the middle of a frame.
        send_beat(16'h0400, 16'h0400, 1'b1, 1'b0);
        send_beat(16'h0400, 16'h0400, 1'b0, 1'b0);
        idle();
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_out_data", {16'b0, out_data}, 32'd0);
        check("midrst_out_sat", {31'b0, out_sat}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_beat(16'h0400, 16'h0400, 1'b1, 1'b1);
        idle();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
        end
        check("midrst_result_count", got_q.size(), 32'd1);
        expect_result("midrst", 16'h0400, 1'b0);

        // Randomized traffic against the model, with random bubbles and stalls.
        got_q.delete();
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_a      = ($urandom_range(1) != 0) ? 16'($urandom) : 16'($urandom_range(2048) - 1024);
            in_b      = ($urandom_range(1) != 0) ? 16'($urandom) : 16'($urandom_range(2048) - 1024);
            in_first  = ($urandom_range(3) == 0);
            in_last   = ($urandom_range(3) == 0);
            out_ready = ($urandom_range(2) != 0);
            @(posedge clk);
            #1;
        end
        idle();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_pending_results", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sat_mac_pipe.md
# sat_mac_pipe

Pipelined, saturating fixed-point multiply-accumulate unit for the equaliser datapath. It generalises the combinational saturating multiplier into three parts: a parametrised Q-format, a valid/ready streaming interface, and a full-precision accumulator. The accumulator is framed by `first`/`last` markers. Filter-tap sums are formed here and saturated once per frame instead of per product.

## Interface
- `WIDTH`, 16, operand/result width, signed two's complement
- `FRAC`, 10, fractional bits of operands and result (integer part = WIDTH-1-FRAC); legal range 1..WIDTH-2
- `GUARD`, 4, accumulator guard bits; ACC_W = 2*WIDTH+GUARD
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operand beat valid
- `in_ready`  out  1  beat accepted when in_valid & in_ready
- `in_a`, `in_b`  in  WIDTH  signed operands, Q(WIDTH-1-FRAC).FRAC
- `in_first`  in  1  beat starts a new sum
- `in_last`  in  1  beat ends the sum and produces an output
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  WIDTH  saturated result, same Q-format as operands
- `out_sat`  out  1  result was clipped, qualified by out_valid

## Operation
- Global stall: `adv = ~out_valid | out_ready`; `in_ready = adv`. All stage registers hold when adv=0.
- S1 registers a, b, first, last and valid.
- S2 registers the full product P = a*b (2*WIDTH bits, 2*FRAC fractional).
- S3 updates the accumulator, which is sign-extended to ACC_W:
  - first=1: acc <= P.
  - first=0: acc <= acc + P, wrapping modulo 2^ACC_W.
  - No first after reset: the sum continues from 0.
- A valid S3 beat with last=1 loads the output register from the newly updated acc value:
  - Scale: s = acc >>> FRAC (arithmetic shift; truncation toward -inf).
  - Clip: s > 2^(WIDTH-1)-1 gives 0111…1; s < -2^(WIDTH-1) gives 1000…0; either case sets out_sat=1, otherwise out_sat=0.
- first=1 together with last=1 produces a single-product result.
- Output register:
  - Set out_valid when a last beat completes S3.
  - Clear out_valid on an out_valid & out_ready handshake if no new last completes that cycle.
  - If a new last completes in the same cycle as a handshake, load the new result and keep out_valid=1.
- Bubbles (in_valid=0) propagate as invalid stages and do not change acc.
- Reset state: all stage valids 0, acc 0, out_valid 0, out_data 0, out_sat 0. With out_valid=0, in_ready=1.
- Reset asserted mid-frame discards all in-flight beats and the partial sum. No output is produced for that frame.

## Timing
- Latency: a last beat accepted at edge t gives out_valid=1 after edge t+3, with no stall.
- Throughput: one beat per cycle while out_ready=1 or out_valid=0.
- While out_valid=1 & out_ready=0:
  - in_ready=0.
  - S1–S3 and acc freeze.
  - out_data and out_sat are stable.
- No combinational path from in_valid to out_valid.
- in_ready depends combinationally on out_ready.

## Configuration
- `SAT_MAC_ROUND_EN` defined:
  - The scale step computes s = (acc + 2^(FRAC-1)) >>> FRAC, i.e. round half up, before clipping.
  - The rounding add must not wrap; use one extra bit.
- Undefined: pure truncation as described in Operation.
- Handshake, latency and saturation are identical in both builds.

## Test plan
All vectors use WIDTH=16, FRAC=10, so 1.0 = 0x0400.

- **Single product:** a=0x0800, b=0x0C00, first=last=1, out_ready=1 → out_data=0x1800, out_sat=0, out_valid exactly 3 cycles after accept.
- **Saturation:**
  - 0x7FFF*0x7FFF single → 0x7FFF, out_sat=1.
  - 0x7FFF*0x8000 → 0x8000, out_sat=1.
  - 0x8000*0x8000 → 0x7FFF, out_sat=1.
- **4-beat frame:** four beats 0x0400*0x0200 (first on beat 0, last on beat 3), then back-to-back first/last single 0x0400*0x0400 → outputs 0x0800, then 0x0400. acc restarts correctly, with no cycle gap.
- **Rounding:**
  - 0x0001*0x0200 → 0x0000 (truncate) or 0x0001 (SAT_MAC_ROUND_EN).
  - 0xFFFF*0x0200 → 0xFFFF (truncate) or 0x0000 (round).
- **Backpressure:** stream 8 single-product beats with out_ready toggled 1,0,0,1,… → in_ready=0 whenever out_valid&~out_ready; out_data held stable; all 8 results delivered in order, none lost or duplicated.
- **Reset mid-frame:** after 2 beats of a 4-beat frame, pulse rst_n low for 1 cycle → all outputs 0 during reset. Next frame 0x0400*0x0400 (first=last) → 0x0400 with no residue from the earlier partial sum.
